// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX operand info and memory/branch status in,
// PC / IF/ID / ID/EX control strobes and performance counters out.
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       if_rs1;
   logic [4:0]       if_rs2;
   logic [4:0]       id_rd;
   logic             id_ex_MemRead;
   logic             mem_busy;
   logic             branch_taken;
   logic             pc_write;
   logic             if_id_write;
   logic             id_ex_bubble;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             freeze;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output if_rs1, if_rs2, id_rd, id_ex_MemRead, mem_busy, branch_taken,
      input  pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, freeze,
      input  stall_cnt, flush_cnt
   );

   modport slave (
      input  if_rs1, if_rs2, id_rd, id_ex_MemRead, mem_busy, branch_taken,
      output pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, freeze,
      output stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall, memory-busy freeze and branch flush controller for the ID/EX boundary.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
   parameter int LOAD_USE_BUBBLES = 1,
   parameter int CNT_W            = 32
) (
   input logic         clk,
   input logic         rst,
   hazard_ctrl_if.slave hz
);

   localparam int REM_W = 2;

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      LU_STALL    = 2'd1,
      MEM_WAIT    = 2'd2,
      MEM_WAIT_BR = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [REM_W-1:0] rem_q, rem_d;

   logic hit;
   logic run_eval;
   logic pc_write;
   logic if_id_write;
   logic id_ex_bubble;
   logic if_id_flush;
   logic id_ex_flush;
   logic freeze;

   assign hit = hz.id_ex_MemRead && (hz.id_rd != 5'd0) &&
                ((hz.id_rd == hz.if_rs1) || (hz.id_rd == hz.if_rs2));

   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      run_eval     = 1'b0;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      freeze       = 1'b0;

      unique case (state_q)
         RUN: run_eval = 1'b1;

         LU_STALL: begin
            if (hz.mem_busy) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               freeze      = 1'b1;
               rem_d       = '0;
               state_d     = hz.branch_taken ? MEM_WAIT_BR : MEM_WAIT;
            end else if (hz.branch_taken) begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               rem_d       = '0;
               state_d     = RUN;
            end else begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
               rem_d        = rem_q - REM_W'(1);
               if (rem_q == REM_W'(1)) begin
                  state_d = RUN;
               end
            end
         end

         MEM_WAIT, MEM_WAIT_BR: begin
            if (hz.mem_busy) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               freeze      = 1'b1;
               if (hz.branch_taken) begin
                  state_d = MEM_WAIT_BR;
               end
            end else if (state_q == MEM_WAIT_BR) begin
               // Branch remembered across the freeze: flush exactly once on release.
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               state_d     = RUN;
            end else begin
               state_d  = RUN;
               run_eval = 1'b1;
            end
         end

         default: state_d = RUN;
      endcase

      if (run_eval) begin
         if (hz.mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            freeze      = 1'b1;
            state_d     = hz.branch_taken ? MEM_WAIT_BR : MEM_WAIT;
         end else if (hz.branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = RUN;
         end else if (hit) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_USE_BUBBLES > 1) begin
               rem_d   = REM_W'(LOAD_USE_BUBBLES - 1);
               state_d = LU_STALL;
            end
         end
      end

      if (rst) begin
         pc_write     = 1'b1;
         if_id_write  = 1'b1;
         id_ex_bubble = 1'b0;
         if_id_flush  = 1'b0;
         id_ex_flush  = 1'b0;
         freeze       = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   assign hz.pc_write     = pc_write;
   assign hz.if_id_write  = if_id_write;
   assign hz.id_ex_bubble = id_ex_bubble;
   assign hz.if_id_flush  = if_id_flush;
   assign hz.id_ex_flush  = id_ex_flush;
   assign hz.freeze       = freeze;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Both counters saturate rather than wrap.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (if_id_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;
`else
   assign hz.stall_cnt = '0;
   assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: one instance with a single load-use bubble and one with three,
// both driven with the same directed vectors; a negedge monitor pops and checks expectations.
module tb_hazard_ctrl;

   localparam int CW = 32;

   // Output encoding: {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, freeze}
   localparam logic [5:0] IDL = 6'b110000;
   localparam logic [5:0] STL = 6'b001000;
   localparam logic [5:0] FRZ = 6'b000001;
   localparam logic [5:0] FLS = 6'b110110;

`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(CW)) hz1 ();
   hazard_ctrl_if #(.CNT_W(CW)) hz3 ();

   hazard_ctrl #(.LOAD_USE_BUBBLES(1), .CNT_W(CW)) u_b1 (
      .clk (clk),
      .rst (rst),
      .hz  (hz1)
   );

   hazard_ctrl #(.LOAD_USE_BUBBLES(3), .CNT_W(CW)) u_b3 (
      .clk (clk),
      .rst (rst),
      .hz  (hz3)
   );

   typedef struct {
      string      name;
      logic       r;
      logic [5:0] e1;
      logic [5:0] e3;
   } exp_t;

   exp_t sb[$];
   exp_t cur;

   int compared   = 0;
   int mismatched = 0;

   logic [CW-1:0] stall1 = '0, flush1 = '0, stall3 = '0, flush3 = '0;

   logic [5:0] act1, act3;
   assign act1 = {hz1.pc_write, hz1.if_id_write, hz1.id_ex_bubble,
                  hz1.if_id_flush, hz1.id_ex_flush, hz1.freeze};
   assign act3 = {hz3.pc_write, hz3.if_id_write, hz3.id_ex_bubble,
                  hz3.if_id_flush, hz3.id_ex_flush, hz3.freeze};

   // Drive one cycle of inputs to both instances and queue what each should show.
   task automatic applyStimulus(input string nm, input logic r,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic mr,
                                input logic mb, input logic br,
                                input logic [5:0] e1, input logic [5:0] e3);
      exp_t e;
      @(posedge clk);
      #1;
      rst               = r;
      hz1.if_rs1        = rs1;  hz3.if_rs1        = rs1;
      hz1.if_rs2        = rs2;  hz3.if_rs2        = rs2;
      hz1.id_rd         = rd;   hz3.id_rd         = rd;
      hz1.id_ex_MemRead = mr;   hz3.id_ex_MemRead = mr;
      hz1.mem_busy      = mb;   hz3.mem_busy      = mb;
      hz1.branch_taken  = br;   hz3.branch_taken  = br;
      e.name = nm;
      e.r    = r;
      e.e1   = e1;
      e.e3   = e3;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input string nm, input logic [CW-1:0] act,
                              input logic [CW-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: every cycle that has a queued expectation is checked at the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            cur = sb.pop_front();
            if (cur.r) begin
               stall1 = '0; flush1 = '0; stall3 = '0; flush3 = '0;
            end
            checkOutput({cur.name, " b1 ctrl"}, CW'(act1), CW'(cur.e1));
            checkOutput({cur.name, " b3 ctrl"}, CW'(act3), CW'(cur.e3));
            checkOutput({cur.name, " b1 stall_cnt"}, hz1.stall_cnt, PERF ? stall1 : '0);
            checkOutput({cur.name, " b1 flush_cnt"}, hz1.flush_cnt, PERF ? flush1 : '0);
            checkOutput({cur.name, " b3 stall_cnt"}, hz3.stall_cnt, PERF ? stall3 : '0);
            checkOutput({cur.name, " b3 flush_cnt"}, hz3.flush_cnt, PERF ? flush3 : '0);
            if (!cur.r) begin
               if (!cur.e1[5]) stall1++;
               if (cur.e1[2])  flush1++;
               if (!cur.e3[5]) stall3++;
               if (cur.e3[2])  flush3++;
            end
         end
      end
   end

   initial begin
      hz1.if_rs1 = '0; hz1.if_rs2 = '0; hz1.id_rd = '0;
      hz1.id_ex_MemRead = 1'b0; hz1.mem_busy = 1'b0; hz1.branch_taken = 1'b0;
      hz3.if_rs1 = '0; hz3.if_rs2 = '0; hz3.id_rd = '0;
      hz3.id_ex_MemRead = 1'b0; hz3.mem_busy = 1'b0; hz3.branch_taken = 1'b0;

      //             name          r  rs1 rs2 rd mr mb br  b1   b3
      applyStimulus("reset0",      1, 0,  0,  0, 0, 0, 0, IDL, IDL);
      applyStimulus("reset_hit",   1, 0,  5,  5, 1, 0, 0, IDL, IDL);
      applyStimulus("idle",        0, 0,  0,  0, 0, 0, 0, IDL, IDL);

      applyStimulus("lu_rs2",      0, 0,  5,  5, 1, 0, 0, STL, STL);
      applyStimulus("lu_rs2_c1",   0, 0,  0,  0, 0, 0, 0, IDL, STL);
      applyStimulus("lu_rs2_c2",   0, 0,  0,  0, 0, 0, 0, IDL, STL);
      applyStimulus("lu_rs2_c3",   0, 0,  0,  0, 0, 0, 0, IDL, IDL);

      applyStimulus("rd_zero",     0, 0,  0,  0, 1, 0, 0, IDL, IDL);
      applyStimulus("no_load",     0, 5,  5,  5, 0, 0, 0, IDL, IDL);

      applyStimulus("lu_rs1",      0, 7,  1,  7, 1, 0, 0, STL, STL);
      applyStimulus("lu_rs1_c1",   0, 0,  0,  0, 0, 0, 0, IDL, STL);
      applyStimulus("lu_rs1_c2",   0, 0,  0,  0, 0, 0, 0, IDL, STL);
      applyStimulus("lu_rs1_c3",   0, 0,  0,  0, 0, 0, 0, IDL, IDL);

      applyStimulus("mw_1",        0, 0,  0,  0, 0, 1, 0, FRZ, FRZ);
      applyStimulus("mw_2_br",     0, 0,  0,  0, 0, 1, 1, FRZ, FRZ);
      applyStimulus("mw_3",        0, 0,  0,  0, 0, 1, 0, FRZ, FRZ);
      applyStimulus("mw_4",        0, 0,  0,  0, 0, 1, 0, FRZ, FRZ);
      applyStimulus("mw_exit",     0, 0,  0,  0, 0, 0, 0, FLS, FLS);
      applyStimulus("mw_after",    0, 0,  0,  0, 0, 0, 0, IDL, IDL);

      applyStimulus("br_and_hit",  0, 5,  0,  5, 1, 0, 1, FLS, FLS);
      applyStimulus("br_after",    0, 0,  0,  0, 0, 0, 0, IDL, IDL);

      applyStimulus("rst_lu_hit",  0, 9,  0,  9, 1, 0, 0, STL, STL);
      applyStimulus("rst_lu_rst",  1, 0,  0,  0, 0, 0, 0, IDL, IDL);
      applyStimulus("rst_lu_c1",   0, 0,  0,  0, 0, 0, 0, IDL, IDL);
      applyStimulus("rst_lu_c2",   0, 0,  0,  0, 0, 0, 0, IDL, IDL);

      applyStimulus("lu_br_hit",   0, 0,  4,  4, 1, 0, 0, STL, STL);
      applyStimulus("lu_br_br",    0, 0,  0,  0, 0, 0, 1, FLS, FLS);
      applyStimulus("lu_br_after", 0, 0,  0,  0, 0, 0, 0, IDL, IDL);

      applyStimulus("lu_mb_hit",   0, 6,  0,  6, 1, 0, 0, STL, STL);
      applyStimulus("lu_mb_busy",  0, 0,  0,  0, 0, 1, 0, FRZ, FRZ);
      applyStimulus("lu_mb_exit",  0, 0,  0,  0, 0, 0, 0, IDL, IDL);

      applyStimulus("ex_hit_busy", 0, 0,  0,  0, 0, 1, 0, FRZ, FRZ);
      applyStimulus("ex_hit",      0, 0,  3,  3, 1, 0, 0, STL, STL);
      applyStimulus("ex_hit_c1",   0, 0,  0,  0, 0, 0, 0, IDL, STL);
      applyStimulus("ex_hit_c2",   0, 0,  0,  0, 0, 0, 0, IDL, STL);
      applyStimulus("ex_hit_c3",   0, 0,  0,  0, 0, 0, 0, IDL, IDL);

      applyStimulus("pulse_mb_br", 0, 0,  0,  0, 0, 1, 1, FRZ, FRZ);
      applyStimulus("pulse_exit",  0, 0,  0,  0, 0, 0, 0, FLS, FLS);
      applyStimulus("pulse_after", 0, 0,  0,  0, 0, 0, 0, IDL, IDL);

      applyStimulus("exbr_busy",   0, 0,  0,  0, 0, 1, 0, FRZ, FRZ);
      applyStimulus("exbr_exit",   0, 2,  0,  2, 1, 0, 1, FLS, FLS);
      applyStimulus("exbr_after",  0, 0,  0,  0, 0, 0, 0, IDL, IDL);

      for (int i = 0; i < 10 && sb.size() > 0; i++) begin
         @(posedge clk);
      end
      if (sb.size() > 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and stall controller on the consumer side of the ID/EX pipeline register. Compares the ID-stage source registers against the load destination held in ID/EX and issues load-use bubbles. Freezes the whole pipeline while the multi-cycle data memory is busy, and flushes IF/ID and ID/EX on a taken branch, remembering a branch that resolves during a freeze. Outputs drive the PC write enable, the IF/ID write/flush controls and the ID/EX bubble/flush controls.

## Interface
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard; legal 1..3
- CNT_W, 32, width of performance counters
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- if_rs1  in  5  rs1 of instruction in ID
- if_rs2  in  5  rs2 of instruction in ID
- id_rd  in  5  destination register held in ID/EX
- id_ex_MemRead  in  1  ID/EX instruction is a load
- mem_busy  in  1  data memory not ready; pipeline must hold
- branch_taken  in  1  EX resolved a taken branch; may be a 1-cycle pulse
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- id_ex_bubble  out  1  zero all ID/EX control bits this cycle
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_flush  out  1  clear ID/EX to NOP
- freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- stall_cnt  out  CNT_W  cycles with pc_write=0
- flush_cnt  out  CNT_W  cycles with if_id_flush=1

## Operation
- Hazard hit: id_ex_MemRead=1, id_rd≠0, id_rd equals if_rs1 or if_rs2.
- Stall outputs: pc_write=0, if_id_write=0, id_ex_bubble=1. Freeze outputs: pc_write=0, if_id_write=0, freeze=1. Flush outputs: if_id_flush=1, id_ex_flush=1, pc_write=1.
- Idle output values: pc_write=1, if_id_write=1, all other outputs 0.
- FSM states: RUN, LU_STALL, MEM_WAIT, MEM_WAIT_BR. Priority in every state: mem_busy, then branch, then hazard.
- RUN:
  - mem_busy → freeze outputs; go to MEM_WAIT, or to MEM_WAIT_BR if branch_taken is also high.
  - else branch_taken → flush outputs, stay in RUN. The hazard is ignored.
  - else hit → stall outputs. If LOAD_USE_BUBBLES>1, load remaining counter with LOAD_USE_BUBBLES-1 and go to LU_STALL.
- LU_STALL:
  - Stall outputs every cycle; remaining counter decrements.
  - Return to RUN in the cycle remaining==1.
  - mem_busy → MEM_WAIT; remaining bubbles discarded.
  - branch_taken → flush outputs, go to RUN.
- MEM_WAIT: freeze outputs while mem_busy=1. branch_taken → MEM_WAIT_BR.
- Exit from MEM_WAIT or MEM_WAIT_BR, in the first cycle with mem_busy=0:
  - In MEM_WAIT_BR, or if branch_taken is high → flush outputs.
  - Otherwise evaluate as RUN, including a hazard hit.
  - Next state is RUN, or LU_STALL if a multi-bubble hit occurs on exit.
- Control outputs are combinational from the state and the inputs; only the state and counters are registered.

## Timing
- Reset: state=RUN, remaining counter=0, stall_cnt=0, flush_cnt=0.
- While rst=1, outputs are forced to idle values.
- Load-use: hit seen in cycle N → stalls in cycles N..N+LOAD_USE_BUBBLES-1; pc_write=1 at N+LOAD_USE_BUBBLES.
- Branch: flush is asserted in the same cycle as branch_taken. A deferred flush is asserted in the first cycle with mem_busy=0, exactly one cycle long.
- mem_busy→freeze has zero latency. A 1-cycle mem_busy pulse produces one freeze cycle.
- rst asserted mid-stall or mid-wait: immediate return to RUN; any pending branch is lost.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments each cycle pc_write=0, including freeze cycles.
  - flush_cnt increments each cycle if_id_flush=1.
  - Both counters saturate at all-ones.
- Undefined: counters are not built; stall_cnt and flush_cnt are tied to 0.

## Test plan
- id_ex_MemRead=1, id_rd=5, if_rs2=5, LOAD_USE_BUBBLES=1 → one cycle pc_write=0, id_ex_bubble=1, then idle; stall_cnt=1.
- Same hit with id_rd=0 → no stall, pc_write stays 1.
- LOAD_USE_BUBBLES=3, hit on rs1=7 → three consecutive stall cycles, then RUN.
- mem_busy high 4 cycles, branch_taken pulse in wait cycle 2 → freeze=1 for 4 cycles, then one cycle if_id_flush=id_ex_flush=1; flush_cnt=1.
- branch_taken and hit in the same cycle → flush only, id_ex_bubble=0, pc_write=1.
- rst pulse during LU_STALL (LOAD_USE_BUBBLES=3, cycle 2) → outputs idle immediately; counters 0; no further stall after rst drops.
